// File: rtl/velocity_cell_ctrl.sv
// velocity_cell_ctrl: reads a cell's particle count and streams its velocity words from a single-port RAM.
// Optional VEL_CTRL_WB_PRIORITY_EN lets write-back preempt read issue; by default reads win.
module velocity_cell_ctrl #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] rd_index,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_rden,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  err
);
    typedef enum logic [2:0] {IDLE, CNT_RD, CNT_WAIT, STREAM, DRAIN, DONE} state_t;
    localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
    localparam logic [ADDR_WIDTH:0]   PN      = (ADDR_WIDTH + 1)'(PARTICLE_NUM);
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d, addr_q, addr_d, fl_idx_q, fl_idx_d, cnt_raw;
    logic                  fl_q, fl_d, err_q, err_d, wp_q, wp_d, rp_q, rp_d;
    logic [1:0]            cnt_q, cnt_d, occ;
    logic [DATA_WIDTH-1:0] fd_q [2], fd_d [2];
    logic [ADDR_WIDTH-1:0] fi_q [2], fi_d [2];
    logic                  pop, want_rd, rd_issue, wb_fire, wb_ok;
    always_comb begin
        occ      = cnt_q + {1'b0, fl_q};
        pop      = rst_n && (cnt_q != 2'd0) && rd_ready;
        // A same-cycle pop frees a slot, which is what keeps one word per cycle flowing
        want_rd  = (state_q == CNT_RD) ||
                   (state_q == STREAM && (occ < 2'd2 || (pop && occ == 2'd2)));
`ifdef VEL_CTRL_WB_PRIORITY_EN
        wb_ready = rst_n;
        rd_issue = rst_n && want_rd && !wb_valid;
`else
        rd_issue = rst_n && want_rd;
        wb_ready = rst_n && !rd_issue;
`endif
        wb_fire     = wb_valid && wb_ready;
        wb_ok       = (wb_addr != '0) && ({1'b0, wb_addr} < PN);
        ram_rden    = rd_issue;
        ram_wren    = wb_fire && wb_ok;
        ram_address = rd_issue ? ((state_q == CNT_RD) ? '0 : addr_q) : wb_addr;
        ram_data    = wb_data;
        busy           = rst_n && (state_q != IDLE);
        done           = rst_n && (state_q == DONE);
        rd_valid       = rst_n && (cnt_q != 2'd0);
        rd_data        = fd_q[rp_q];
        rd_index       = fi_q[rp_q];
        particle_count = count_q;
        err            = err_q;
    end
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        addr_d   = addr_q;
        err_d    = err_q || (wb_fire && !wb_ok);
        fl_d     = rd_issue && (state_q == STREAM);
        fl_idx_d = addr_q;
        cnt_raw  = ram_q[ADDR_WIDTH-1:0];
        unique case (state_q)
            IDLE:     state_d = start ? CNT_RD : IDLE;
            CNT_RD:   state_d = rd_issue ? CNT_WAIT : CNT_RD;
            CNT_WAIT: begin
                count_d = (cnt_raw > MAX_CNT) ? MAX_CNT : cnt_raw;
                err_d   = err_d || (cnt_raw > MAX_CNT);
                addr_d  = ADDR_WIDTH'(1);
                state_d = (cnt_raw == '0) ? DONE : STREAM;
            end
            STREAM: begin
                addr_d  = rd_issue ? addr_q + 1'b1 : addr_q;
                state_d = (rd_issue && addr_q == count_q) ? DRAIN : STREAM;
            end
            DRAIN:    state_d = (cnt_q == 2'd0 && !fl_q) ? DONE : DRAIN;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end
    always_comb begin
        fd_d = fd_q;
        fi_d = fi_q;
        if (fl_q) begin
            fd_d[wp_q] = ram_q;
            fi_d[wp_q] = fl_idx_q;
        end
        wp_d  = fl_q ? ~wp_q : wp_q;
        rp_d  = pop ? ~rp_q : rp_q;
        cnt_d = cnt_q + {1'b0, fl_q} - {1'b0, pop};
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            addr_q   <= '0;
            fl_idx_q <= '0;
            fl_q     <= 1'b0;
            err_q    <= 1'b0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            fl_idx_q <= fl_idx_d;
            fl_q     <= fl_d;
            err_q    <= err_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            cnt_q    <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        fd_q <= fd_d;
        fi_q <= fi_d;
    end
endmodule

// File: tb/tb_velocity_cell_ctrl.sv
// tb_velocity_cell_ctrl: scoreboard bench with a 1-cycle-latency RAM model for velocity_cell_ctrl.
module tb_velocity_cell_ctrl;
    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;
    logic clk = 0, rst_n = 0, start = 0, rd_ready = 0, wb_valid = 0;
    logic [AW-1:0] wb_addr = '0;
    logic [DW-1:0] wb_data = '0;
    logic busy, done, rd_valid, wb_ready, ram_rden, ram_wren, err;
    logic [AW-1:0] particle_count, rd_index, ram_address;
    logic [DW-1:0] rd_data, ram_data, ram_q;
    logic [DW-1:0] mem [256];
    typedef struct packed {logic [AW-1:0] idx; logic [DW-1:0] data;} word_t;
    word_t sb[$];
    word_t w;
    int total = 0, bad = 0, cyc = 0, done_cnt = 0, valid_cnt = 0, gap_cnt = 0, last_pop = -10;
    int d0, v0, g0, n;
    logic held = 0, stop;
    logic [DW-1:0] hd, old;
    logic [AW-1:0] hi;

    velocity_cell_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .particle_count(particle_count), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_index(rd_index), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_addr(wb_addr), .wb_data(wb_data), .ram_address(ram_address), .ram_data(ram_data),
        .ram_rden(ram_rden), .ram_wren(ram_wren), .ram_q(ram_q), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        if (ram_rden) ram_q <= mem[ram_address];
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] wv(input int i, input int s);
        return {32'(s), 32'hDEAD0000 | 32'(i), 32'(i * 7 + s)};
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (ram_rden || ram_wren) chk("rden_wren_exclusive", DW'(ram_rden && ram_wren), 0);
`ifndef VEL_CTRL_WB_PRIORITY_EN
        if (ram_rden) chk("wb_ready_low_on_read", DW'(wb_ready), 0);
`endif
        if (done) done_cnt++;
        if (rd_valid) valid_cnt++;
        if (held && rd_valid) begin
            chk("stall_hold_data", rd_data, hd);
            chk("stall_hold_index", DW'(rd_index), DW'(hi));
        end
        if (rd_valid && rd_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got index %0d, expected no word", rd_index);
            end else begin
                w = sb.pop_front();
                chk("rd_index", DW'(rd_index), DW'(w.idx));
                chk("rd_data", rd_data, w.data);
            end
            if (last_pop != cyc - 1) gap_cnt++;
            last_pop = cyc;
        end
        held = rd_valid && !rd_ready;
        hd = rd_data;
        hi = rd_index;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int cnt, input int s);
        mem[0] <= DW'(cnt);
        for (int i = 1; i < 256; i++) mem[i] <= wv(i, s);
    endtask

    task automatic expect_words(input int cnt, input int s);
        for (int i = 1; i <= cnt; i++) sb.push_back({AW'(i), wv(i, s)});
    endtask

    task automatic do_start();
        tick();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < budget);
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no done after %0d cycles, expected done", name, k);
        end
        tick();
    endtask

    task automatic snap();
        d0 = done_cnt;
        v0 = valid_cnt;
        g0 = gap_cnt;
    endtask

    task automatic reset_outputs_low(input string name);
        @(negedge clk);
        chk({name, "_busy"}, DW'(busy), 0);
        chk({name, "_done"}, DW'(done), 0);
        chk({name, "_rd_valid"}, DW'(rd_valid), 0);
        chk({name, "_ram_rden"}, DW'(ram_rden), 0);
        chk({name, "_ram_wren"}, DW'(ram_wren), 0);
        chk({name, "_wb_ready"}, DW'(wb_ready), 0);
    endtask

    initial begin
        rst_n = 0;
        fill(0, 0);
        tick();
        reset_outputs_low("rst");
        tick();
        chk("rst_particle_count", DW'(particle_count), 0);
        chk("rst_err", DW'(err), 0);
        rst_n = 1;
        rd_ready = 1;

        fill(3, 1);
        expect_words(3, 1);
        snap();
        do_start();
        wait_done("basic", 40);
        chk("basic_count", DW'(particle_count), 3);
        chk("basic_err", DW'(err), 0);
        chk("basic_done_pulses", DW'(done_cnt - d0), 1);
        chk("basic_back_to_back", DW'(gap_cnt - g0), 1);
        chk("basic_sb_empty", DW'(sb.size()), 0);
        chk("basic_idle_busy", DW'(busy), 0);

        fill(0, 2);
        snap();
        do_start();
        wait_done("zero", 20);
        chk("zero_valid_cycles", DW'(valid_cnt - v0), 0);
        chk("zero_done_pulses", DW'(done_cnt - d0), 1);
        chk("zero_count", DW'(particle_count), 0);
        chk("zero_err", DW'(err), 0);

        fill(5, 3);
        expect_words(5, 3);
        snap();
        do_start();
        stop = 0;
        fork
            begin
                wait_done("stall", 200);
                stop = 1;
            end
            begin
                int k;
                k = 0;
                while (!stop) begin
                    rd_ready = (k % 4 == 0) || (k % 4 == 3);
                    k++;
                    tick();
                end
            end
        join
        rd_ready = 1;
        chk("stall_sb_empty", DW'(sb.size()), 0);
        chk("stall_done_pulses", DW'(done_cnt - d0), 1);
        chk("stall_count", DW'(particle_count), 5);

        fill(5, 4);
        expect_words(5, 4);
        snap();
        do_start();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rd_valid && n < 30);
        chk("midrst_stream_started", DW'(rd_valid), 1);
        tick();
        rst_n = 0;
        sb.delete();
        reset_outputs_low("midrst");
        tick();
        rst_n = 1;
        chk("midrst_count_cleared", DW'(particle_count), 0);
        chk("midrst_err_cleared", DW'(err), 0);
        repeat (10) tick();
        chk("midrst_no_done", DW'(done_cnt - d0), 0);
        chk("midrst_idle", DW'(busy), 0);
        fill(2, 5);
        expect_words(2, 5);
        snap();
        do_start();
        wait_done("restart", 40);
        chk("restart_count", DW'(particle_count), 2);
        chk("restart_done_pulses", DW'(done_cnt - d0), 1);
        chk("restart_sb_empty", DW'(sb.size()), 0);

        fill(250, 6);
        expect_words(PN - 1, 6);
        snap();
        do_start();
        wait_done("clamp", 600);
        chk("clamp_count", DW'(particle_count), 219);
        chk("clamp_err", DW'(err), 1);
        chk("clamp_words", DW'(valid_cnt - v0), 219);
        chk("clamp_sb_empty", DW'(sb.size()), 0);

        tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("wb_err_cleared", DW'(err), 0);
`ifdef VEL_CTRL_WB_PRIORITY_EN
        fill(5, 7);
        expect_words(5, 7);
        snap();
        do_start();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rd_valid && n < 30);
        chk("wbprio_stream_started", DW'(rd_valid), 1);
        tick();
        wb_valid = 1;
        wb_addr = 2;
        wb_data = 96'h1234_5678_9ABC_DEF0_0BAD_F00D;
        @(negedge clk);
        chk("wbprio_wb_ready", DW'(wb_ready), 1);
        repeat (4) tick();
        wb_valid = 0;
        wait_done("wbprio", 60);
        chk("wbprio_ram2", mem[2], 96'h1234_5678_9ABC_DEF0_0BAD_F00D);
        chk("wbprio_done_pulses", DW'(done_cnt - d0), 1);
        chk("wbprio_sb_empty", DW'(sb.size()), 0);
        chk("wbprio_err", DW'(err), 0);
`else
        wb_valid = 1;
        wb_addr = 2;
        wb_data = 96'h1234_5678_9ABC_DEF0_0BAD_F00D;
        @(negedge clk);
        chk("wb_idle_ready", DW'(wb_ready), 1);
        tick();
        wb_valid = 0;
        tick();
        chk("wb_ram2", mem[2], 96'h1234_5678_9ABC_DEF0_0BAD_F00D);
        chk("wb_legal_err", DW'(err), 0);
`endif
        old = mem[230];
        wb_valid = 1;
        wb_addr = 230;
        wb_data = 96'hFFFF;
        tick();
        wb_valid = 0;
        tick();
        chk("wb_oob_ram230", mem[230], old);
        chk("wb_oob_err", DW'(err), 1);
        old = mem[0];
        wb_valid = 1;
        wb_addr = 0;
        wb_data = 96'hBEEF;
        tick();
        wb_valid = 0;
        tick();
        chk("wb_addr0_ram0", mem[0], old);
        chk("wb_addr0_err", DW'(err), 1);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/velocity_cell_ctrl.md
VELOCITY_CELL_CTRL -- requirements
Module: velocity_cell_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 96, meaning velocity word width {vz,vy,vx}.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning velocity RAM address width.
REQ-003 SHALL have parameter PARTICLE_NUM, default 220, meaning RAM depth; address 0 holds the particle count.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning synchronous active-low reset.
REQ-006 SHALL have ports start (input, 1, begin cell readout pulse), busy (output, 1), done (output, 1, one-cycle pulse).
REQ-007 SHALL have port particle_count, output, ADDR_WIDTH, meaning the count latched from address 0.
REQ-008 SHALL have ports rd_valid (output, 1), rd_ready (input, 1), rd_data (output, DATA_WIDTH), rd_index (output, ADDR_WIDTH), forming the read-out stream.
REQ-009 SHALL have ports wb_valid (input, 1), wb_ready (output, 1), wb_addr (input, ADDR_WIDTH), wb_data (input, DATA_WIDTH), forming the write-back stream.
REQ-010 SHALL have RAM-side ports ram_address (output, ADDR_WIDTH), ram_data (output, DATA_WIDTH), ram_rden (output, 1), ram_wren (output, 1), ram_q (input, DATA_WIDTH).
REQ-011 SHALL have port err, output, 1, meaning a sticky error flag.

Function
REQ-012 SHALL use states IDLE, CNT_RD, CNT_WAIT, STREAM, DRAIN, DONE.
REQ-013 IDLE: SHALL move to CNT_RD on start; start is ignored while busy.
REQ-014 CNT_RD: SHALL issue a read of address 0, then move to CNT_WAIT.
REQ-015 CNT_WAIT: SHALL latch ram_q[ADDR_WIDTH-1:0] into particle_count one cycle after the read, since RAM read latency is exactly 1 cycle.
REQ-016 If the count is 0, SHALL go to DONE; if it exceeds PARTICLE_NUM-1, SHALL clamp it to PARTICLE_NUM-1, set err, and go to STREAM.
REQ-017 STREAM: SHALL issue reads at addresses 1..count in ascending order and go to DRAIN after the last issue.
REQ-018 SHALL buffer returned data in a 2-entry output FIFO and issue a read only when FIFO occupancy plus in-flight reads is below 2.
REQ-019 SHALL sustain one word per cycle while rd_ready is held high.
REQ-020 rd_index SHALL equal the RAM address of rd_data; rd_data and rd_index SHALL hold stable while rd_valid && !rd_ready.
REQ-021 DRAIN: SHALL move to DONE once the FIFO is empty and no read is in flight.
REQ-022 DONE: SHALL pulse done for one cycle, then return to IDLE; busy SHALL be high in every state except IDLE.
REQ-023 Write-back SHALL be accepted in any state on wb_valid && wb_ready, driving ram_wren=1, ram_address=wb_addr, ram_data=wb_data for that cycle.
REQ-024 ram_rden and ram_wren SHALL never both be 1 in the same cycle, because the RAM is single-port.
REQ-025 A write-back with wb_addr==0 or wb_addr>=PARTICLE_NUM SHALL be accepted, SHALL NOT be written, and SHALL set err.
REQ-026 err SHALL clear only on reset.

Reset
REQ-027 On rst_n==0 at a clock edge: state=IDLE, FIFO flushed, in-flight reads discarded, particle_count=0, err=0.
REQ-028 During reset: busy, done, rd_valid, ram_rden and ram_wren SHALL be 0, and wb_ready SHALL be 0.
REQ-029 Reset asserted mid-stream SHALL abort with no done pulse; RAM data returning after reset SHALL be dropped.

Configuration
REQ-030 With VEL_CTRL_WB_PRIORITY_EN defined: wb_ready=1 outside reset; a write-back preempts a pending read issue, and that read issues on the next free cycle.
REQ-031 Without VEL_CTRL_WB_PRIORITY_EN: wb_ready=0 in any cycle where a read is issued, giving reads priority.

Verification
REQ-032 RAM[0]=3, RAM[1..3]=A,B,C, start, rd_ready=1 -> rd_index 1,2,3 with data A,B,C on consecutive cycles; done pulses once; particle_count=3.
REQ-033 RAM[0]=0, start -> done pulses with rd_valid never asserted; err=0.
REQ-034 RAM[0]=250, PARTICLE_NUM=220 -> particle_count=219, err=1, and 219 words are streamed.
REQ-035 count=5, rd_ready toggling 1,0,0,1... -> all 5 words delivered in order, none lost or duplicated, data held stable during stalls.
REQ-036 With VEL_CTRL_WB_PRIORITY_EN, wb_valid held high during STREAM with wb_addr=2 -> RAM[2] updated, no rden/wren overlap, stream completes; a wb_addr=0 write leaves RAM[0] unchanged and sets err.
REQ-037 rst_n low for one cycle mid-stream -> outputs return to reset values, no done pulse; a subsequent start re-reads address 0.
